// File: rtl/uart_rx_ctl_if.sv
// Signal bundle between the 3-byte ADC frame decoder, its UART receiver and the
// sample consumer. The master side is the decoder, the slave side is the receiver/consumer.
interface uart_rx_ctl_if;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        uld_rx_data;
    logic        rx_enable;
    logic [31:0] adc_word;
    logic        word_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    modport master (
        input  rx_data, rx_empty,
        output uld_rx_data, rx_enable, adc_word, word_valid, frame_err, frame_cnt
    );

    modport slave (
        output rx_data, rx_empty,
        input  uld_rx_data, rx_enable, adc_word, word_valid, frame_err, frame_cnt
    );
endinterface

// File: rtl/uart_rx_ctl.sv
// Receive-side decoder of the 3-byte ADC frame: unloads bytes from a UART receiver,
// assembles b0/b1/b2, decodes them into a 32-bit sample word and drops partial
// frames whose inter-byte gap exceeds TIMEOUT_CYCLES.
module uart_rx_ctl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic          clock,
    input  logic          reset,
    uart_rx_ctl_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ULD     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DECODE  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  byte_idx_r;
    logic [7:0]  slot0_r;
    logic [7:0]  slot1_r;
    logic [7:0]  slot2_r;
    logic [23:0] gap_cnt_r;
    logic        gap_count_s;
    logic        timeout_s;
    logic        uld_next_s;
    logic        word_valid_next_s;
    logic        frame_err_next_s;
    logic        uld_r;
    logic        rx_enable_r;
    logic        word_valid_r;
    logic        frame_err_r;
    logic [31:0] adc_word_r;
    logic [15:0] frame_cnt_r;

    // All-ones frame is the "no sample" marker; a lone 0x01 in b2 with zero b1 and
    // zero low nibble in b0 is a b0-only sample; anything else is a full 24-bit sample.
    function automatic logic [31:0] decode_word(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
        logic [31:0] word;
        if ((b0 == 8'hFF) && (b1 == 8'hFF) && (b2 == 8'hFF)) begin
            word = 32'h0000_0000;
        end else if ((b0[3:0] == 4'h0) && (b1 == 8'h00) && (b2 == 8'h01)) begin
            word = {b0, 24'h00_0000};
        end else begin
            word = {b0, b1, b2, 8'h00};
        end
        return word;
    endfunction

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a byte is only noticed while waiting in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.rx_empty) begin
                    next_state_s = ST_ULD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ULD:  next_state_s = ST_WAIT;
            ST_WAIT: next_state_s = ST_CAPTURE;
            ST_CAPTURE: begin
                if (byte_idx_r == 2'd2) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DECODE: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Inter-byte gap detection; an arriving byte (rx_empty=0) suppresses the timeout.
    always_comb begin
        gap_count_s = (state_r == ST_IDLE) && (byte_idx_r != 2'd0) && bus.rx_empty;
        if (gap_count_s && (gap_cnt_r == (TIMEOUT_CYCLES - 24'd1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next values of the registered strobes, derived from the FSM.
    always_comb begin
        uld_next_s        = (next_state_s == ST_ULD);
        word_valid_next_s = (state_r == ST_DECODE);
        frame_err_next_s  = timeout_s;
    end

    // Output strobe registers; rx_enable rises on the first edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uld_r        <= 1'b0;
            rx_enable_r  <= 1'b0;
            word_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            uld_r        <= uld_next_s;
            rx_enable_r  <= 1'b1;
            word_valid_r <= word_valid_next_s;
            frame_err_r  <= frame_err_next_s;
        end
    end

    // Byte index, byte slots and gap counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx_r <= 2'd0;
            slot0_r    <= 8'h00;
            slot1_r    <= 8'h00;
            slot2_r    <= 8'h00;
            gap_cnt_r  <= 24'd0;
        end else begin
            if (timeout_s) begin
                byte_idx_r <= 2'd0;
                slot0_r    <= 8'h00;
                slot1_r    <= 8'h00;
                slot2_r    <= 8'h00;
            end else if (state_r == ST_CAPTURE) begin
                case (byte_idx_r)
                    2'd0:    slot0_r <= bus.rx_data;
                    2'd1:    slot1_r <= bus.rx_data;
                    2'd2:    slot2_r <= bus.rx_data;
                    default: slot2_r <= slot2_r;
                endcase
                if (byte_idx_r == 2'd2) begin
                    byte_idx_r <= 2'd0;
                end else begin
                    byte_idx_r <= byte_idx_r + 2'd1;
                end
            end
            if (gap_count_s && !timeout_s) begin
                gap_cnt_r <= gap_cnt_r + 24'd1;
            end else begin
                gap_cnt_r <= 24'd0;
            end
        end
    end

    // Decoded word and frame counter, updated only on the edge leaving DECODE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            adc_word_r  <= 32'h0000_0000;
            frame_cnt_r <= 16'h0000;
        end else if (state_r == ST_DECODE) begin
            adc_word_r  <= decode_word(slot0_r, slot1_r, slot2_r);
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign bus.uld_rx_data = uld_r;
    assign bus.rx_enable   = rx_enable_r;
    assign bus.adc_word    = adc_word_r;
    assign bus.word_valid  = word_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.frame_cnt   = frame_cnt_r;
endmodule
